// File: rtl/shift_access_arbiter.sv
// Round-robin arbiter that lets two requesters share one serial shift register.
// It clears the register, feeds the selected bits serially, then returns the parallel result.
module shift_access_arbiter #(
  parameter int WIDTH = 4,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_dir,
  input  logic [LW-1:0]    req0_len,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_dir,
  input  logic [LW-1:0]    req1_len,
  input  logic [WIDTH-1:0] req1_data,
  output logic             sh_in,
  output logic             sh_sel,
  output logic             sh_rstn,
  input  logic [WIDTH-1:0] sh_q,
  output logic             busy,
  output logic             done_valid,
  output logic             done_id,
  output logic [WIDTH-1:0] done_data
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic             dir_r;
  logic             id_r;
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    bitcnt;
  logic [WIDTH-1:0] data_r;

  logic             grant0;
  logic             grant1;
  logic             any_valid;
  logic [LW-1:0]    sh_idx;
  logic [WIDTH-1:0] shifted;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len > LW'(WIDTH)) begin
      return LW'(WIDTH);
    end else begin
      return len;
    end
  endfunction

  // Round-robin choice: on a tie the requester not granted last time wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant0    = req0_valid & (~req1_valid | last_grant);
    grant1    = req1_valid & (~req0_valid | ~last_grant);
  end

  // Control FSM plus latched command fields.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      dir_r      <= 1'b0;
      id_r       <= 1'b0;
      len_r      <= {LW{1'b0}};
      bitcnt     <= {LW{1'b0}};
      data_r     <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            id_r       <= grant1;
            last_grant <= grant1;
            dir_r      <= grant1 ? req1_dir : req0_dir;
            len_r      <= clamp_len(grant1 ? req1_len : req0_len);
            data_r     <= grant1 ? req1_data : req0_data;
            bitcnt     <= {LW{1'b0}};
            state      <= CLR;
          end else begin
            state <= IDLE;
          end
        end
        CLR: begin
          state <= (len_r == {LW{1'b0}}) ? DONE : SHIFT;
        end
        SHIFT: begin
          bitcnt <= bitcnt + LW'(1);
          if (bitcnt == len_r - LW'(1)) begin
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; everything is forced to its reset value while rstn is low.
  always_comb begin
    sh_idx     = dir_r ? bitcnt : (len_r - LW'(1) - bitcnt);
    shifted    = data_r >> sh_idx;
    req0_ready = rstn & (state == IDLE) & grant0;
    req1_ready = rstn & (state == IDLE) & grant1;
    busy       = rstn & (state != IDLE);
    sh_rstn    = ~(rstn & (state == CLR));
    sh_sel     = rstn & (state == SHIFT) & dir_r;
    sh_in      = rstn & (state == SHIFT) & shifted[0];
    done_valid = rstn & (state == DONE);
    if (done_valid) begin
      done_id   = id_r;
      done_data = sh_q;
    end else begin
      done_id   = 1'b0;
      done_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_shift_access_arbiter.sv
// Bench for shift_access_arbiter: directed commands against a transaction-level model
// of the arbiter plus a behavioural shift register standing in for the datapath.
module tb_shift_access_arbiter;
  localparam int WIDTH = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req0_valid = 1'b0, req0_dir = 1'b0, req1_valid = 1'b0, req1_dir = 1'b0;
  logic [LW-1:0] req0_len = '0, req1_len = '0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, sh_in, sh_sel, sh_rstn, busy, done_valid, done_id;
  logic [WIDTH-1:0] done_data;
  logic [WIDTH-1:0] sr_q = '0;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  shift_access_arbiter #(.WIDTH(WIDTH), .LW(LW)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir),
    .req0_len(req0_len), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir),
    .req1_len(req1_len), .req1_data(req1_data),
    .sh_in(sh_in), .sh_sel(sh_sel), .sh_rstn(sh_rstn), .sh_q(sr_q),
    .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_data(done_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared bidirectional shift register: sel=1 shifts toward q[0], sel=0 toward q[WIDTH-1].
  always @(posedge clk) begin
    if (!sh_rstn) sr_q <= '0;
    else if (sh_sel) sr_q <= {sh_in, sr_q[WIDTH-1:1]};
    else sr_q <= {sr_q[WIDTH-2:0], sh_in};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one accepted command, phases derived from cycles since accept.
  bit m_known = 0, m_active = 0, m_last = 1, m_dir = 0, m_id = 0;
  int m_t = 0, m_len = 0;
  logic [WIDTH-1:0] m_data = '0;

  always @(negedge clk) begin
    int k, i, msk;
    logic e_r0, e_r1, e_busy, e_rst, e_in, e_sel, e_dv, e_id;
    logic [WIDTH-1:0] e_dd;
    if (!rstn) begin
      chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);         chk("rst_done_valid", done_valid, 0);
      chk("rst_done_id", done_id, 0);   chk("rst_done_data", done_data, 0);
      chk("rst_sh_rstn", sh_rstn, 1);   chk("rst_sh_in", sh_in, 0);
      chk("rst_sh_sel", sh_sel, 0);
      m_known = 1; m_active = 0; m_last = 1;
    end else if (m_known) begin
      e_r0 = 0; e_r1 = 0; e_busy = 0; e_rst = 1; e_in = 0; e_sel = 0;
      e_dv = 0; e_id = 0; e_dd = '0; k = 0;
      if (!m_active) begin
        if (req0_valid && (!req1_valid || m_last)) e_r0 = 1;
        else if (req1_valid) e_r1 = 1;
      end else begin
        k = cyc - m_t;
        e_busy = 1;
        if (k == 1) e_rst = 0;
        else if (k >= 2 && k <= 1 + m_len) begin
          i = k - 2;
          e_sel = m_dir;
          e_in = m_dir ? m_data[i] : m_data[m_len - 1 - i];
        end else if (k == 2 + m_len) begin
          msk = (1 << m_len) - 1;
          e_dv = 1; e_id = m_id;
          e_dd = m_dir ? WIDTH'((int'(m_data) & msk) << (WIDTH - m_len))
                       : WIDTH'(int'(m_data) & msk);
        end
      end
      chk("m_ready0", req0_ready, e_r0); chk("m_ready1", req1_ready, e_r1);
      chk("m_busy", busy, e_busy);       chk("m_sh_rstn", sh_rstn, e_rst);
      chk("m_sh_in", sh_in, e_in);       chk("m_sh_sel", sh_sel, e_sel);
      chk("m_done_valid", done_valid, e_dv);
      chk("m_done_id", done_id, e_id);   chk("m_done_data", done_data, e_dd);
      if (m_active && k == 2 + m_len) m_active = 0;
      else if (!m_active && (e_r0 || e_r1)) begin
        m_active = 1; m_t = cyc; m_id = e_r1; m_last = e_r1;
        m_dir  = e_r1 ? req1_dir : req0_dir;
        m_len  = e_r1 ? int'(req1_len) : int'(req0_len);
        if (m_len > WIDTH) m_len = WIDTH;
        m_data = e_r1 ? req1_data : req0_data;
      end
    end
  end

  task automatic send(input int r, input bit dir, input logic [LW-1:0] len,
                      input logic [WIDTH-1:0] data, output int acc_id, output int lat,
                      output logic [WIDTH-1:0] res, output logic [7:0] seq);
    bit acc, got;
    int t0, clen;
    acc = 0; got = 0; t0 = 0; acc_id = -1; lat = -1; res = 'x; seq = '0;
    clen = (int'(len) > WIDTH) ? WIDTH : int'(len);
    if (r == 0) begin req0_dir = dir; req0_len = len; req0_data = data; req0_valid = 1'b1; end
    else begin req1_dir = dir; req1_len = len; req1_data = data; req1_valid = 1'b1; end
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin acc = 1; acc_id = req1_ready; t0 = cyc; end
    end
    chk("accept_timeout", acc, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (cyc >= t0 + 2 && cyc <= t0 + 1 + clen) seq = {seq[6:0], sh_in};
      if (done_valid) begin got = 1; lat = cyc - t0; res = done_data; end
    end
    chk("done_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int id, lat, na, nd;
    logic [WIDTH-1:0] res;
    logic [7:0] seq;
    int acc_id[4], acc_cyc[4], dn_id[4];
    logic [WIDTH-1:0] dn_data[4];

    // Reset with both requesters asking.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready0", req0_ready, 0);
    chk("reset_ready1", req1_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sh_rstn", sh_rstn, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;

    // Right shift, full length.
    send(0, 1'b1, 3'd4, 4'b1011, id, lat, res, seq);
    chk("right_id", id, 0); chk("right_lat", lat, 6);
    chk("right_data", res, 4'b1011); chk("right_seq", seq[3:0], 4'b1101);

    // Partial loads from requester 1.
    send(1, 1'b0, 3'd3, 4'b0110, id, lat, res, seq);
    chk("partial_left_id", id, 1); chk("partial_left_lat", lat, 5);
    chk("partial_left_data", res, 4'b0110);
    send(1, 1'b1, 3'd2, 4'b0001, id, lat, res, seq);
    chk("partial_right_lat", lat, 4); chk("partial_right_data", res, 4'b0100);

    // Contention: both held valid, grants must alternate starting with 0.
    req0_dir = 1'b0; req0_len = 3'd2; req0_data = 4'b0011;
    req1_dir = 1'b1; req1_len = 3'd2; req1_data = 4'b0010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    na = 0; nd = 0;
    for (int n = 0; n < 60 && nd < 4; n++) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && na < 4) begin
        acc_id[na] = req1_ready; acc_cyc[na] = cyc; na++;
      end
      if (done_valid) begin dn_id[nd] = done_id; dn_data[nd] = done_data; nd++; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_accepts", na, 4); chk("cont_dones", nd, 4);
    for (int j = 0; j < 4 && j < na && j < nd; j++) begin
      chk("cont_grant", acc_id[j], j % 2);
      chk("cont_done_id", dn_id[j], j % 2);
      chk("cont_done_data", dn_data[j], (j % 2) ? 4'b1000 : 4'b0011);
      if (j > 0) chk("cont_spacing", acc_cyc[j] - acc_cyc[j-1], 5);
    end
    @(posedge clk); #1;

    // Corner lengths.
    send(0, 1'b0, 3'd0, 4'b1111, id, lat, res, seq);
    chk("len0_lat", lat, 2); chk("len0_data", res, 4'b0000);
    send(1, 1'b1, 3'd7, 4'b1011, id, lat, res, seq);
    chk("len7_lat", lat, 6); chk("len7_data", res, 4'b1011);
    chk("len7_seq", seq[3:0], 4'b1101);

    // Reset during the second SHIFT cycle.
    req0_dir = 1'b0; req0_len = 3'd4; req0_data = 4'b0101; req0_valid = 1'b1;
    na = 0;
    for (int n = 0; n < 20 && na == 0; n++) begin
      @(negedge clk);
      if (req0_ready) na = 1;
    end
    chk("midrst_accept", na, 1);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    nd = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_valid) nd++;
    end
    chk("midrst_no_done", nd, 0);
    @(posedge clk); #1;
    req1_dir = 1'b0; req1_len = 3'd4; req1_data = 4'b1001; req1_valid = 1'b1;
    send(0, 1'b0, 3'd4, 4'b0110, id, lat, res, seq);
    chk("post_rst_tie_id", id, 0); chk("post_rst_lat", lat, 6);
    chk("post_rst_data", res, 4'b0110);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_access_arbiter.md
# shift_access_arbiter

Controller that shares one WIDTH-bit bidirectional serial shift register between two requesters. Each requester submits a load command with a direction, a bit length and a data word. The block arbitrates round-robin and clears the shared register. It then serially feeds the selected bits through the register's `in`/`sel` pins and returns the parallel `q` contents with the requester ID. It sits between the two client blocks and the shift-register datapath; it drives that datapath's `in`, `sel` and `rstn` pins and observes its `q`.

## Interface
- `WIDTH`, default 4: width of the shared shift register and of the command data.
- `LW`, default `$clog2(WIDTH)+1`: width of the length fields.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, synchronous, active-low; clock `clk`.
- `req0_valid` in 1: requester 0 has a command pending.
- `req0_ready` out 1: requester 0 command accepted this cycle.
- `req0_dir` in 1: 1 = shift toward q[0] (`sel`=1); 0 = shift toward q[WIDTH-1] (`sel`=0).
- `req0_len` in LW: number of bits to shift in, legal range 1..WIDTH.
- `req0_data` in WIDTH: bits to load; only `data[len-1:0]` is used.
- `req1_valid`, `req1_ready`, `req1_dir`, `req1_len`, `req1_data`: same as requester 0, for requester 1.
- `sh_in` out 1: serial input to the shift register.
- `sh_sel` out 1: direction select to the shift register.
- `sh_rstn` out 1: synchronous active-low clear to the shift register.
- `sh_q` in WIDTH: parallel output of the shift register.
- `busy` out 1: high in every state except IDLE.
- `done_valid` out 1: one-cycle result pulse; there is no backpressure.
- `done_id` out 1: requester that owns the result.
- `done_data` out WIDTH: register contents; valid only while `done_valid` is high.

## Operation
- The FSM has four states: IDLE, CLR, SHIFT, DONE. Reset puts it in IDLE.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester and assert its `reqN_ready` for that cycle only (combinational from state and valids).
  - On the clock edge, latch `dir`, `len`, `data` and `id`, load `bitcnt`=0, and go to CLR.
  - With no valid request, stay in IDLE.
- **Arbitration**
  - A single requester always wins.
  - When both requesters are valid, the one not granted last wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `last_grant` updates only on an accept.
- **CLR** (one cycle): `sh_rstn`=0, which zeroes the register at the edge. Next state is SHIFT, or DONE if the latched len is 0.
- **Length clamping**: a latched len greater than WIDTH is clamped to WIDTH at latch time. A len of 0 is accepted and returns all zeros.
- **SHIFT** (len cycles): `sh_sel`=dir. `bitcnt` increments each cycle; leave for DONE when `bitcnt`==len-1.
  - dir=0: `sh_in` = data[len-1-bitcnt] (MSB first). Result: q = zero-extended data[len-1:0].
  - dir=1: `sh_in` = data[bitcnt] (LSB first). Result: q = data[len-1:0] << (WIDTH-len).
- **DONE** (one cycle): `done_valid`=1, `done_id` = latched id, `done_data` = `sh_q`. Next state is IDLE.
- **Outputs outside SHIFT**: `sh_in`=0 and `sh_sel`=0. The register keeps shifting zeros, and its contents outside DONE are don't-care.
- **Output decode**: `sh_rstn` = 0 only in CLR. `sh_in` and `sh_sel` are decoded from registered state and latched fields, with no combinational path from the request inputs.
- **Requester rule**: a requester must hold valid and its fields stable until ready. Fields are sampled only on the accept edge.

## Timing
- Accept in cycle T (IDLE, ready=1). CLR is T+1, SHIFT is T+2..T+1+len, DONE is T+2+len.
- Result latency is len+2 cycles after the accept cycle. Back-to-back throughput is one command per len+3 cycles, because DONE always returns to IDLE.
- `reqN_ready` is never high outside IDLE, and never high for both requesters in the same cycle.
- **Reset values**: state=IDLE, `busy`=0, `req0_ready`=`req1_ready`=0, `done_valid`=0, `done_id`=0, `done_data`=0, `sh_rstn`=1, `sh_in`=0, `sh_sel`=0, `last_grant`=1.
- **Reset mid-operation**: `rstn` low in any state returns to IDLE at the next edge. The in-flight command is dropped and produces no `done_valid`. A DONE cycle coinciding with `rstn` low produces no pulse.
- **Request dropped before grant**: a valid deasserted before ready is never granted and has no side effects.

## Test plan
- **Reset**: hold `rstn`=0 for 2 cycles with both valids high -> both readys=0, `done_valid`=0, `busy`=0, `sh_rstn`=1.
- **Right shift**: requester 0 sends dir=1, len=4, data=4'b1011 -> `req0_ready` at T, `sh_in` sequence 1,1,0,1 with `sh_sel`=1, `done_valid` at T+6 with `done_id`=0 and `done_data`=4'b1011.
- **Partial loads**: requester 1 sends dir=0, len=3, data=4'b0110 -> `done_data`=4'b0110, `done_id`=1 at T+5. Then dir=1, len=2, data=4'b0001 -> `done_data`=4'b0100.
- **Contention**: both valid continuously with distinct data -> grants alternate 0,1,0,1, one accept every len+3 cycles, `done_id` alternates matching the data.
- **Corner lengths**: len=0 -> `done_data`=0 at T+2. len=7 with WIDTH=4 -> behaves exactly as len=4.
- **Reset mid-operation**: `rstn`=0 during the 2nd SHIFT cycle -> no `done_valid`, state IDLE. A new request after reset completes correctly and is granted to requester 0 on a tie.
